// File: rtl/mips_pkg.sv
// mips_pkg: ALU operation codes and register constants shared by the MIPS datapath
package mips_pkg;
    typedef enum logic [4:0] {
        ALU_AND  = 5'd0,
        ALU_ANDI = 5'd1,
        ALU_ADD  = 5'd2,
        ALU_ADDI = 5'd3,
        ALU_SLL  = 5'd4,
        ALU_SLT  = 5'd7,
        ALU_LW   = 5'd8,
        ALU_SW   = 5'd9,
        ALU_BEQ  = 5'd10,
        ALU_JAL  = 5'd11,
        ALU_NOR  = 5'd12,
        ALU_JR   = 5'd15
    } alu_op_t;
    localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// forward_mux: picks EX/MEM, then MEM/WB, then register-file data for one source specifier
module forward_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      spec,
    input  logic [XLEN-1:0] rf_data,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] data
);
    logic nz;
    assign nz   = spec != 5'd0;
    assign data = (nz && exm_reg_write && exm_rd == spec) ? exm_result :
                  (nz && wb_reg_write && wb_rd == spec)   ? wb_result  : rf_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, load-use bubbles and ALU operand selection
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [4:0]       id_shamt,
    input  logic [4:0]       id_alu_control,
    input  logic             id_alu_src,
    input  logic             id_uses_rt,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             exm_reg_write,
    input  logic [4:0]       exm_rd,
    input  logic [XLEN-1:0]  exm_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_result,
    output logic [XLEN-1:0]  alu_in_1,
    output logic [XLEN-1:0]  alu_in_2,
    output logic [4:0]       alu_control,
    output logic [4:0]       shamt,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [4:0]       ex_dest,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] bubble_count
);
    logic [4:0]      rs, rt;
    logic [XLEN-1:0] rs_data, rt_data, imm, rt_fwd;
    logic            alu_src, bubble;

    assign load_use_stall = ex_valid && ex_mem_read && ex_dest != 5'd0 && id_valid &&
                            (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt));
    // flush wins over stall; a load-use bubble only enters when the stage is not held
    assign bubble = flush || (!stall && load_use_stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            alu_control   <= ALU_ADD;
            shamt         <= '0;
            ex_dest       <= '0;
            rs            <= '0;
            rt            <= '0;
            rs_data       <= '0;
            rt_data       <= '0;
            imm           <= '0;
            alu_src       <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            alu_control   <= id_alu_control;
            shamt         <= id_shamt;
            ex_dest       <= id_alu_control == ALU_JAL ? REG_RA : id_reg_dst ? id_rd : id_rt;
            rs            <= id_rs;
            rt            <= id_rt;
            rs_data       <= id_rs_data;
            rt_data       <= id_rt_data;
            imm           <= id_imm;
            alu_src       <= id_alu_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_count <= '0;
        else if (bubble && bubble_count != '1)
            bubble_count <= bubble_count + 1'b1;
    end

    forward_mux #(.XLEN(XLEN)) u_fwd_rs (
        .spec(rs), .rf_data(rs_data),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .data(alu_in_1)
    );

    forward_mux #(.XLEN(XLEN)) u_fwd_rt (
        .spec(rt), .rf_data(rt_data),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .data(rt_fwd)
    );

    assign ex_store_data = rt_fwd;
    assign alu_in_2      = alu_src ? imm : rt_fwd;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors checked against a per-cycle behavioural model plus literal expectations
module tb_id_ex_stage;
    logic        clk, rst_n, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm, exm_result, wb_result;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt, id_alu_control, exm_rd, wb_rd;
    logic        id_alu_src, id_uses_rt, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exm_reg_write, wb_reg_write;
    logic [31:0] alu_in_1, alu_in_2, ex_store_data;
    logic [4:0]  alu_control, shamt, ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;
    logic [15:0] bubble_count;
    int          n_cmp = 0, n_err = 0;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_uses_rt(id_uses_rt),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_control(alu_control), .shamt(shamt),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
        logic [4:0]  op, sh, dest, rs, rt;
        logic [31:0] rs_data, rt_data, imm;
    } slot_t;

    slot_t m;
    int    m_cnt;

    function automatic slot_t empty_slot();
        slot_t s;
        s    = '0;
        s.op = 5'd2;
        return s;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 0) return d;
        if (exm_reg_write && exm_rd == r) return exm_result;
        if (wb_reg_write && wb_rd == r) return wb_result;
        return d;
    endfunction

    function automatic logic hazard();
        if (!(m.valid && m.mem_read && m.dest != 0 && id_valid)) return 1'b0;
        return m.dest == id_rs || (id_uses_rt && m.dest == id_rt);
    endfunction

    function automatic slot_t decoded();
        slot_t s;
        s.valid = id_valid; s.reg_write = id_reg_write; s.mem_read = id_mem_read;
        s.mem_write = id_mem_write; s.mem_to_reg = id_mem_to_reg; s.alu_src = id_alu_src;
        s.op = id_alu_control; s.sh = id_shamt; s.rs = id_rs; s.rt = id_rt;
        s.dest = (id_alu_control == 5'd11) ? 5'd31 : (id_reg_dst ? id_rd : id_rt);
        s.rs_data = id_rs_data; s.rt_data = id_rt_data; s.imm = id_imm;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= empty_slot();
            m_cnt <= 0;
        end else if (flush || (!stall && hazard())) begin
            m     <= empty_slot();
            m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        end else if (!stall) begin
            m <= decoded();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.ex_valid", ex_valid, m.valid);
        chk("m.ex_reg_write", ex_reg_write, m.reg_write);
        chk("m.ex_mem_read", ex_mem_read, m.mem_read);
        chk("m.ex_mem_write", ex_mem_write, m.mem_write);
        chk("m.ex_mem_to_reg", ex_mem_to_reg, m.mem_to_reg);
        chk("m.alu_control", alu_control, m.op);
        chk("m.shamt", shamt, m.sh);
        chk("m.ex_dest", ex_dest, m.dest);
        chk("m.alu_in_1", alu_in_1, fwd(m.rs, m.rs_data));
        chk("m.alu_in_2", alu_in_2, m.alu_src ? m.imm : fwd(m.rt, m.rt_data));
        chk("m.ex_store_data", ex_store_data, fwd(m.rt, m.rt_data));
        chk("m.load_use_stall", load_use_stall, hazard());
        chk("m.bubble_count", bubble_count, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic reg_dst, input logic src,
                             input logic [31:0] imm, input logic mr);
        id_valid = 1; id_alu_control = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_reg_dst = reg_dst; id_alu_src = src; id_imm = imm; id_mem_read = mr;
        id_mem_to_reg = mr; id_reg_write = 1; id_mem_write = 0; id_uses_rt = !src;
        id_shamt = 5'd3;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_shamt = 0; id_alu_control = 5'd2; id_alu_src = 0; id_uses_rt = 0; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0; wb_reg_write = 0; wb_rd = 0; wb_result = 0;
        repeat (2) tick();
        chk("rst.ex_valid", ex_valid, 0);
        chk("rst.alu_control", alu_control, 2);
        rst_n = 1;
        #1;
        chk("rel.alu_in_1", alu_in_1, 0);
        chk("rel.bubble_count", bubble_count, 0);
        // forwarding priority
        set_instr(5'd2, 5'd5, 5'd6, 5'd3, 1, 0, 0, 0);
        id_rs_data = 32'h11; id_rt_data = 32'h66;
        exm_reg_write = 1; exm_rd = 5; exm_result = 32'h22;
        wb_reg_write = 1; wb_rd = 5; wb_result = 32'h33;
        tick();
        chk("fwd.exm", alu_in_1, 32'h22);
        chk("fwd.dest", ex_dest, 3);
        chk("fwd.rt_plain", alu_in_2, 32'h66);
        exm_reg_write = 0; #1;
        chk("fwd.wb", alu_in_1, 32'h33);
        wb_reg_write = 0; #1;
        chk("fwd.rf", alu_in_1, 32'h11);
        // register zero never forwarded
        id_rs = 0; id_rs_data = 32'h44; exm_rd = 0; exm_reg_write = 1; exm_result = 32'hFF;
        tick();
        chk("zero.alu_in_1", alu_in_1, 32'h44);
        exm_reg_write = 0;
        // load-use
        set_instr(5'd8, 5'd0, 5'd8, 5'd0, 0, 1, 32'd4, 1);
        tick();
        chk("lw.dest", ex_dest, 8);
        chk("lw.alu_in_2", alu_in_2, 4);
        set_instr(5'd2, 5'd8, 5'd9, 5'd10, 1, 0, 0, 0);
        id_rs_data = 32'h100; id_rt_data = 32'h200;
        #1;
        chk("lu.stall", load_use_stall, 1);
        tick();
        chk("lu.bubble_valid", ex_valid, 0);
        chk("lu.bubble_op", alu_control, 2);
        chk("lu.count", bubble_count, 1);
        chk("lu.released", load_use_stall, 0);
        tick();
        chk("lu.add_valid", ex_valid, 1);
        chk("lu.add_dest", ex_dest, 10);
        chk("lu.add_in_1", alu_in_1, 32'h100);
        chk("lu.add_store", ex_store_data, 32'h200);
        // stall together with flush loads a bubble
        stall = 1; flush = 1;
        tick();
        chk("sf.valid", ex_valid, 0);
        chk("sf.count", bubble_count, 2);
        stall = 0; flush = 0;
        // stall together with load-use holds
        set_instr(5'd8, 5'd0, 5'd8, 5'd0, 0, 1, 32'd4, 1);
        tick();
        set_instr(5'd2, 5'd8, 5'd9, 5'd10, 1, 0, 0, 0);
        stall = 1; #1;
        chk("sl.stall_out", load_use_stall, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold.valid", ex_valid, 1);
            chk("hold.dest", ex_dest, 8);
            chk("hold.op", alu_control, 8);
            chk("hold.count", bubble_count, 2);
        end
        stall = 0;
        // addi immediate operand
        set_instr(5'd3, 5'd1, 5'd2, 5'd0, 0, 1, 32'hFFFFFFFC, 0);
        tick();
        chk("addi.in_2", alu_in_2, 32'hFFFFFFFC);
        chk("addi.dest", ex_dest, 2);
        chk("addi.count", bubble_count, 2);
        // jal destination
        set_instr(5'd11, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0);
        tick();
        chk("jal.dest", ex_dest, 31);
        // flush with load-use counts once
        set_instr(5'd8, 5'd0, 5'd8, 5'd0, 0, 1, 32'd4, 1);
        tick();
        set_instr(5'd2, 5'd8, 5'd9, 5'd10, 1, 0, 0, 0);
        flush = 1;
        tick();
        chk("flu.count", bubble_count, 3);
        chk("flu.valid", ex_valid, 0);
        flush = 0;
        tick();
        chk("flu.captured", ex_dest, 10);
        // asynchronous reset mid-cycle
        @(negedge clk); #2;
        rst_n = 0; #1;
        chk("arst.valid", ex_valid, 0);
        chk("arst.op", alu_control, 2);
        chk("arst.count", bubble_count, 0);
        tick();
        rst_n = 1;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the MIPS datapath, directly upstream of `alu`. It registers decoded operands and control from the decode stage, applies EX/MEM and MEM/WB result forwarding, and selects register or immediate for the second operand. It also detects load-use hazards and inserts bubbles, and drives the ALU inputs `in_1`, `in_2`, `alu_control` and `shamt`.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CNT_W`, 16, width of the bubble counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `stall`  in  1  downstream hold; the stage keeps its contents.
- `flush`  in  1  squash; the stage loads a bubble.
- `id_valid`  in  1  the decode stage presents an instruction.
- `id_rs_data`, `id_rt_data`  in  XLEN  register-file read data.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`  in  5  register specifiers.
- `id_shamt`  in  5  shift amount.
- `id_alu_control`  in  5  ALU operation code.
- `id_alu_src`  in  1  1 selects the immediate for `alu_in_2`.
- `id_uses_rt`  in  1  the instruction reads rt as a source.
- `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1  decoded control.
- `exm_reg_write`  in  1  EX/MEM write enable.
- `exm_rd`  in  5  EX/MEM destination register.
- `exm_result`  in  XLEN  EX/MEM ALU result.
- `wb_reg_write`  in  1  MEM/WB write enable.
- `wb_rd`  in  5  MEM/WB destination register.
- `wb_result`  in  XLEN  MEM/WB write-back value.
- `alu_in_1`, `alu_in_2`  out  XLEN  ALU operands (forwarded).
- `alu_control`, `shamt`  out  5  to the ALU.
- `ex_store_data`  out  XLEN  forwarded rt value, used by sw.
- `ex_dest`  out  5  write-back destination.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  out  1  registered control.
- `load_use_stall`  out  1  tells the PC and IF/ID to hold.
- `bubble_count`  out  CNT_W  number of inserted bubbles; saturates.

## Operation
- Each rising edge takes exactly one action, chosen by this priority:
  - `flush`: load a bubble.
  - `stall`: hold all registers.
  - `load_use_stall`: load a bubble.
  - Otherwise: capture the `id_*` inputs, with `ex_valid <= id_valid`.
- A bubble sets `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` and `ex_mem_to_reg` to 0. It sets `alu_control` to ALU_ADD, and all data fields, `ex_dest` and `shamt` to 0.
- Destination captured into `ex_dest`:
  - 31 if `id_alu_control` is ALU_JAL.
  - Otherwise `id_rd` if `id_reg_dst` is 1.
  - Otherwise `id_rt`.
- Load-use detection is combinational. `load_use_stall` = `ex_valid` & `ex_mem_read` & `ex_dest`≠0 & `id_valid` & (`ex_dest`==`id_rs` | (`id_uses_rt` & `ex_dest`==`id_rt`)).
- Forwarding is combinational from the registered operands. It is computed separately for rs (gives `alu_in_1`) and rt (gives `ex_store_data`, and `alu_in_2` when `alu_src` is 0):
  - Register 0 is never forwarded.
  - EX/MEM is used if `exm_reg_write` and `exm_rd` equals the specifier.
  - Otherwise MEM/WB is used if `wb_reg_write` and `wb_rd` equals the specifier.
  - Otherwise the registered register-file data is used.
- When `alu_src` is 1, `alu_in_2` is the registered immediate.
- `bubble_count` increments on every edge that loads a bubble because of `flush` or `load_use_stall`. It holds at all-ones.

## Timing
- Reset: every register and every registered output is 0. `alu_control` is ALU_ADD (value 0b00010). `ex_valid` is 0 and `bubble_count` is 0.
- Latency: an instruction captured at edge N drives the ALU during cycle N+1.
- `load_use_stall` is combinational in the same cycle. The dependent instruction is captured one cycle after the bubble.
- `flush` and `load_use_stall` asserted together: a single bubble is loaded and `bubble_count` increments by 1.
- `stall` and `load_use_stall` asserted together: the stage holds, no bubble is loaded and the count is unchanged.
- Reset asserted mid-stream clears the stage immediately, without waiting for a clock edge.

## Structure
- Package `mips_pkg` holds:
  - 5-bit ALU codes: ALU_AND=0, ALU_ANDI=1, ALU_ADD=2, ALU_ADDI=3, ALU_SLL=4, ALU_SLT=7, ALU_LW=8, ALU_SW=9, ALU_BEQ=10, ALU_JAL=11, ALU_NOR=12, ALU_JR=15.
  - The constant REG_RA=31.
- One sub-module, `forward_mux`, instanced twice (for rs and rt). It takes a specifier, the register data and both forwarding sources, and returns the selected value.

## Test plan
- Reset: release `rst_n` and check `ex_valid`=0, `alu_control`=2, `alu_in_1`=0 and `bubble_count`=0.
- Forwarding priority: rs=5 with `id_rs_data`=0x11, `exm_rd`=5 with `exm_result`=0x22, and `wb_rd`=5 with `wb_result`=0x33 → `alu_in_1`=0x22. Then drop `exm_reg_write` → `alu_in_1`=0x33.
- Zero register: rs=0, `exm_rd`=0 with `exm_reg_write`=1 and `exm_result`=0xFF → `alu_in_1` equals the registered `id_rs_data`.
- Load-use: `lw` to $8 followed by `add` with rs=$8 → `load_use_stall`=1 for one cycle, a bubble the next cycle, `add` captured after that, and `bubble_count`=1.
- Simultaneous events: `stall`=1 together with `flush`=1 → a bubble is loaded. `stall`=1 alone → all outputs held for 3 cycles.
- `jal`: `id_alu_control`=11 with `id_reg_dst`=1 and `id_rd`=4 → `ex_dest`=31. `addi` with `id_alu_src`=1 and `id_imm`=0xFFFFFFFC → `alu_in_2`=0xFFFFFFFC.
